// File: rtl/demux4_capture_pkg.sv
// demux4_capture_pkg: shared channel constants and destination decode
package demux4_capture_pkg;
  localparam int NUM_CH   = 4;
  localparam int CH_SEL_W = 2;
  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_SEL_W-1:0] s);
    return NUM_CH'(1) << s;
  endfunction
endpackage

// File: rtl/demux_channel_reg.sv
// demux_channel_reg: WIDTH-bit holding register with sync active-low clear and load enable
module demux_channel_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_q, data_d;
  always_comb data_d = load ? d : data_q;
  always_ff @(posedge clock)
    if (!resetn) data_q <= '0;
    else         data_q <= data_d;
  assign q = data_q;
endmodule

// File: rtl/demux4_capture.sv
// demux4_capture: routes each valid input sample to one of four registered channels,
// chosen by sel (manual) or a round-robin pointer (auto).
module demux4_capture
  import demux4_capture_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  in_valid,
  input  logic [CH_SEL_W-1:0]   sel,
  input  logic                  auto_mode,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]     out_valid,
  output logic [CH_SEL_W-1:0]   cur_ch,
  output logic                  frame_done
);
  logic [CH_SEL_W-1:0] ptr_q, ptr_d, dest;
  logic [NUM_CH-1:0]   out_valid_q, out_valid_d;
  logic                frame_done_q, frame_done_d;
  always_comb begin
    dest         = auto_mode ? ptr_q : sel;
    // Manual mode parks the pointer at 0 so auto mode always starts a fresh frame.
    ptr_d        = !auto_mode ? '0 : in_valid ? ptr_q + 1'b1 : ptr_q;
    out_valid_d  = in_valid ? onehot(dest) : '0;
    frame_done_d = in_valid && auto_mode && (ptr_q == CH_SEL_W'(NUM_CH - 1));
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      ptr_q        <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_channel_reg #(.WIDTH(WIDTH)) u_reg (
      .clock  (clock),
      .resetn (resetn),
      .load   (in_valid && dest == CH_SEL_W'(k)),
      .d      (data_in),
      .q      (out_data[k*WIDTH +: WIDTH])
    );
  end
  assign out_valid  = out_valid_q;
  assign cur_ch     = ptr_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_demux4_capture.sv
// tb_demux4_capture: directed vector table, corner sequences and random stimulus vs a channel-array model
module tb_demux4_capture;
  logic        clk = 1'b0;
  logic        resetn, in_valid, auto_mode;
  logic [3:0]  data_in;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [1:0]  cur_ch;
  logic        frame_done;
  int cnt = 0, errs = 0;

  always #5 clk = ~clk;

  demux4_capture #(.WIDTH(4)) dut (
    .clock(clk), .resetn(resetn), .data_in(data_in), .in_valid(in_valid),
    .sel(sel), .auto_mode(auto_mode), .out_data(out_data), .out_valid(out_valid),
    .cur_ch(cur_ch), .frame_done(frame_done)
  );

  logic [3:0] m_ch [4];
  int         m_ptr;
  logic [3:0] m_ov;
  logic       m_fd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cnt++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic rn, iv, am, input logic [1:0] s, input logic [3:0] d);
    int dst;
    if (!rn) begin
      foreach (m_ch[i]) m_ch[i] = 4'h0;
      m_ptr = 0; m_ov = 4'h0; m_fd = 1'b0;
    end else begin
      dst  = am ? m_ptr : int'(s);
      m_ov = iv ? 4'(1 << dst) : 4'h0;
      m_fd = iv && am && m_ptr == 3;
      if (iv) m_ch[dst] = d;
      m_ptr = !am ? 0 : iv ? (m_ptr + 1) % 4 : m_ptr;
    end
  endtask

  task automatic cyc(input logic rn, iv, am, input logic [1:0] s, input logic [3:0] d, input bit chk);
    @(negedge clk);
    resetn = rn; in_valid = iv; auto_mode = am; sel = s; data_in = d;
    @(posedge clk);
    #1;
    model(rn, iv, am, s, d);
    if (chk) begin
      check("out_data",   out_data,   {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
      check("out_valid",  out_valid,  m_ov);
      check("cur_ch",     cur_ch,     m_ptr[1:0]);
      check("frame_done", frame_done, m_fd);
    end
  endtask

  typedef struct {
    logic rn, iv, am; logic [1:0] s; logic [3:0] d;
    logic [15:0] e_data; logic [3:0] e_ov; logic [1:0] e_cur; logic e_fd;
  } vec_t;
  vec_t tbl [13];

  initial begin
    tbl[0]  = '{0,1,0,2'd0,4'h1, 16'h0000,4'b0000,2'd0,0};
    tbl[1]  = '{0,1,1,2'd3,4'h1, 16'h0000,4'b0000,2'd0,0};
    tbl[2]  = '{1,1,0,2'd2,4'h1, 16'h0100,4'b0100,2'd0,0};
    tbl[3]  = '{1,1,0,2'd0,4'h1, 16'h0101,4'b0001,2'd0,0};
    tbl[4]  = '{1,0,0,2'd1,4'h9, 16'h0101,4'b0000,2'd0,0};
    tbl[5]  = '{0,0,0,2'd0,4'h0, 16'h0000,4'b0000,2'd0,0};
    tbl[6]  = '{1,1,1,2'd2,4'hA, 16'h000A,4'b0001,2'd1,0};
    tbl[7]  = '{1,1,1,2'd0,4'hB, 16'h00BA,4'b0010,2'd2,0};
    tbl[8]  = '{1,1,1,2'd1,4'hC, 16'h0CBA,4'b0100,2'd3,0};
    tbl[9]  = '{1,1,1,2'd0,4'hD, 16'hDCBA,4'b1000,2'd0,1};
    tbl[10] = '{1,0,1,2'd0,4'h0, 16'hDCBA,4'b0000,2'd0,0};
    tbl[11] = '{1,1,0,2'd3,4'hE, 16'hECBA,4'b1000,2'd0,0};
    tbl[12] = '{1,1,0,2'd3,4'h6, 16'h6CBA,4'b1000,2'd0,0};
    resetn = 0; in_valid = 0; auto_mode = 0; sel = 0; data_in = 0;
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rn, tbl[i].iv, tbl[i].am, tbl[i].s, tbl[i].d, 0);
      check($sformatf("vec%0d out_data", i),   out_data,   tbl[i].e_data);
      check($sformatf("vec%0d out_valid", i),  out_valid,  tbl[i].e_ov);
      check($sformatf("vec%0d cur_ch", i),     cur_ch,     tbl[i].e_cur);
      check($sformatf("vec%0d frame_done", i), frame_done, tbl[i].e_fd);
    end
    // gapped auto input
    cyc(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1, 2'($urandom), 4'(i + 1), 1);
      for (int j = 0; j < 3; j++) cyc(1, 0, 1, 2'($urandom), 4'($urandom), 1);
    end
    check("gap out_data", out_data, 16'h4321);
    // mode switch mid-frame
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 4'h1, 1);
    cyc(1, 1, 1, 0, 4'h2, 1);
    check("sw cur_ch", cur_ch, 2'd2);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 2'd3, 4'h7, 1);
    check("sw out_data", out_data, 16'h0027);
    check("sw out_valid", out_valid, 4'b0001);
    check("sw frame_done", frame_done, 1'b0);
    // reset mid-frame
    cyc(1, 1, 1, 0, 4'h3, 1);
    cyc(1, 1, 1, 0, 4'h4, 1);
    cyc(0, 1, 1, 0, 4'h9, 1);
    cyc(1, 1, 1, 0, 4'h5, 1);
    check("rst out_data", out_data, 16'h0005);
    check("rst out_valid", out_valid, 4'b0001);
    check("rst frame_done", frame_done, 1'b0);
    check("rst cur_ch", cur_ch, 2'd1);
    // random
    begin
      logic am = 1'b1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 15) == 0) am = ~am;
        cyc($urandom_range(0, 39) != 0, 1'($urandom), am, 2'($urandom), 4'($urandom), 1);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", cnt, errs);
    $finish;
  end
endmodule

// File: doc/demux4_capture.md
Name: demux4_capture

Overview:
- Receive-side counterpart to the 4:1 selector: takes one shared input lane and routes each valid sample to one of four registered output channels.
- Channel is chosen either by an explicit 2-bit select (manual) or by an internal round-robin pointer (auto, time-slot de-interleaving).
- Sits between a single time-multiplexed source (switch or upstream mux) and four independent consumers (LED groups or downstream logic).

Parameters:
- WIDTH, 1, bit width of each data sample and of each output channel.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- data_in  input  WIDTH  shared input sample.
- in_valid  input  1  data_in is to be captured this cycle.
- sel  input  2  destination channel in manual mode; ignored in auto mode.
- auto_mode  input  1  1 = round-robin pointer selects the channel; 0 = sel selects it.
- out_data  output  4*WIDTH  held channel registers; channel k occupies [k*WIDTH +: WIDTH].
- out_valid  output  4  one-cycle strobe; bit k is high for one cycle after channel k captures.
- cur_ch  output  2  channel the next auto-mode sample will go to (the pointer value).
- frame_done  output  1  one-cycle strobe after an auto-mode capture into channel 3.

Behaviour:
- Reset: resetn=0 at an edge clears out_data, out_valid, cur_ch and frame_done to 0. Reset overrides a simultaneous in_valid.
- Reset mid-frame: the pointer returns to 0 and the partial frame is discarded. Channel registers clear; no strobes are produced.
- Destination: dest = auto_mode ? ptr : sel, evaluated combinationally in the capture cycle.
- Capture: on an edge with resetn=1 and in_valid=1:
  - channel dest register <= data_in;
  - out_valid <= one-hot(dest);
  - all other channels hold their values.
- No capture: on an edge with in_valid=0, out_valid <= 0 and all channels hold.
- Latency: the captured value and its strobe are visible exactly one cycle after the capture edge.
- Back-to-back: in_valid may be high every cycle. Each cycle's out_valid reflects only the previous edge's capture.
- Pointer (ptr, exposed as cur_ch), auto_mode=1:
  - increments by 1 modulo 4 on every capture (3 wraps to 0);
  - holds when in_valid=0.
- Pointer, auto_mode=0: ptr <= 0 on every edge, so entering auto mode always starts at channel 0.
- Mode switch: the mode is sampled per edge. A capture on the first edge with auto_mode=1 goes to channel 0.
- frame_done: set to 1 for one cycle after an auto-mode capture with ptr=3, otherwise 0. It is never asserted for manual-mode captures, including sel=3.
- Manual mode: repeated captures to the same channel overwrite it; each produces a fresh strobe.
- No X propagation: sel and auto_mode are don't-care only when in_valid=0 and auto_mode=1 respectively; ptr is still updated.

Decomposition:
- Shared package: NUM_CH=4, CH_SEL_W=2, and the one-hot decode function used for out_valid.
- One natural sub-module, demux_channel_reg: a WIDTH-bit register with synchronous active-low clear and load enable, instantiated four times.
- The pointer, destination decode, and strobes stay in the top module.

Test Plan:
- Reset: assert resetn=0 for 2 cycles with in_valid=1 and data_in=1 -> out_data=0, out_valid=0, cur_ch=0, frame_done=0 throughout.
- Manual routing (WIDTH=1): auto_mode=0; capture 1 with sel=2, then 1 with sel=0 -> out_data=4'b0101. out_valid=4'b0100, then 4'b0001, each one cycle. cur_ch stays 0.
- Auto frame (WIDTH=4): auto_mode=1; in_valid high for 4 consecutive cycles with data 0xA, 0xB, 0xC, 0xD:
  - out_data=16'hDCBA;
  - out_valid walks 0001, 0010, 0100, 1000;
  - frame_done=1 only in the cycle after 0xD;
  - cur_ch returns to 0.
- Gapped auto input: auto_mode=1; captures separated by 3 idle cycles -> cur_ch holds between captures and no strobes appear in idle cycles. Channels fill 0→1→2→3 in order.
- Mode switch: auto_mode=1 with 2 captures (cur_ch=2); drop auto_mode for one idle cycle; raise it and capture 0x7 -> 0x7 lands in channel 0, and frame_done stays 0.
- Reset mid-frame: after 3 auto captures, assert resetn=0 for 1 cycle, then capture 0x5 -> out_data=16'h0005, out_valid=0001, and no frame_done.
